ws2811_decoder: RTL and testbench
=================================

// Module: ws2811_decoder
// PURPOSE
//  Receive side of the WS2811 single-wire NRZ protocol, behaving like one WS2811 pixel.
//  Samples the serial line, classifies each high pulse as 0/1 by its width, and assembles
//  the first 24 bits after a latch gap into one GRB pixel word. Flags latch (reset) gaps.
//  Sits after the pixel driver in loopback benches and on boards that listen to a strip.
// PARAMETERS
//  CLK_HZ         50_000_000  clkIN frequency; documentation only, defaults are derived for it
//  THRESHOLD_CLKS 21          high width >= this -> bit 1, else bit 0 (~420 ns)
//  MAX_HIGH_CLKS  75          high width > this -> framing error (~1.5 us)
//  RESET_CLKS     2500        low width >= this -> latch/reset gap (50 us)
//  PIXEL_BITS     24          bits per pixel word, MSB first
// PORTS
//  clkIN          in   1           system clock
//  nResetIN       in   1           asynchronous active-low reset
//  dataIN         in   1           serial line, asynchronous to clkIN
//  pixelOUT       out  PIXEL_BITS  last captured pixel word, bit 23 = first bit received
//  pixelValidOUT  out  1           one-cycle strobe, pixelOUT just updated
//  frameResetOUT  out  1           one-cycle strobe, latch gap detected
//  bitErrorOUT    out  1           one-cycle strobe, framing error
//  dataOUT        out  1           forwarded line (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all outputs 0, bit counter 0, state ST_SYNC. Async assert; counters restart.
//  - dataIN goes through a 2-flop synchronizer. Edge detection uses synchronized value (s).
//  - Width counter saturates at RESET_CLKS. Clears on every edge of s.
//  - ST_SYNC: wait until s has been low for RESET_CLKS cycles.
//      On that cycle: frameResetOUT=1, then go to ST_IDLE. A rising edge before that restarts the count.
//  - ST_IDLE: line low, waiting.
//      Rising edge of s -> ST_HIGH.
//      Low reaches RESET_CLKS -> pulse frameResetOUT, clear bit count, discard partial bits.
//  - ST_HIGH: count high cycles.
//      Count > MAX_HIGH_CLKS -> bitErrorOUT=1, discard partial word, go to ST_SYNC.
//      Falling edge -> shift in (width>=THRESHOLD_CLKS), increment bit count, go to ST_IDLE.
//  - Bit PIXEL_BITS shifted at cycle N -> at N+1 pixelOUT=word and pixelValidOUT=1, then ST_PASS.
//  - ST_PASS: own pixel taken; later bits are ignored, not decoded.
//      Low reaches RESET_CLKS -> frameResetOUT, bit count cleared, go to ST_IDLE.
//  - pixelOUT holds its value until the next full word. A partial word never changes it.
//  - Simultaneous: error and latch are mutually exclusive by state. A latch gap never raises error.
//  - Bit 0 widths at exactly THRESHOLD_CLKS-1; bit 1 at exactly THRESHOLD_CLKS (boundary inclusive).
//  - Input-to-strobe latency: 2 sync + 1 edge + 1 register = 4 clkIN after the falling edge of the last bit.
// CONFIGURATION
//  WS2811_DECODER_FORWARD_EN
//   defined: dataOUT = s in ST_PASS, else 0. This passes downstream bits like a chained pixel.
//            dataOUT is registered, so there is a 3-cycle delay from dataIN.
//   undefined: dataOUT tied 0. ST_PASS is still entered; no forwarding logic is built.
// STRUCTURE
//  - Package ws2811_pkg:
//      state enum {ST_SYNC, ST_IDLE, ST_HIGH, ST_PASS}
//      PIXEL_BITS default
//      width-counter width = $clog2(RESET_CLKS+1)
//  - Sub-module ws2811_sync: 2-flop synchronizer with rise/fall strobes.
//    Async active-low reset, flops reset to 0.
//  - Top module holds the FSM, width counter, shift register and output registers.
// TESTING
//  1 Reset, hold dataIN low 2500 clk -> one frameResetOUT. No pixelValidOUT.
//  2 After latch, send 24 bits of 0xA5C3F0 (1: 30 clk high/32 low; 0: 12 high/50 low)
//    -> pixelValidOUT once, pixelOUT=0xA5C3F0, 4 clk after the last falling edge.
//  3 Send 48 bits (0x123456 then 0xABCDEF), then a 2500-clk gap
//    -> pixelOUT=0x123456 only, then frameResetOUT.
//    With FORWARD_EN: dataOUT replicates the second 24 bits, delayed 3 clk.
//  4 High pulses of 20 and 21 clk -> decoded as 0 and 1 respectively.
//    A 76-clk high -> bitErrorOUT, pixelOUT unchanged, no decode until the next 2500-clk low.
//  5 Send 10 bits, then a 2500-clk low -> frameResetOUT, no pixelValidOUT.
//    The next 24 bits form a fresh word.
//  6 Pull nResetIN low mid-word (bit 12), release -> outputs 0.
//    Bits are ignored until a 2500-clk low gap is seen.

Source files
------------

// File: rtl/ws2811_pkg.sv
// Shared types and defaults for the WS2811 single-pixel receiver.
// Holds the FSM state encoding and width helpers used by ws2811_decoder.
package ws2811_pkg;

    localparam int PIXEL_BITS_DEF = 24;
    localparam int RESET_CLKS_DEF = 2500;

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_IDLE = 2'd1,
        ST_HIGH = 2'd2,
        ST_PASS = 2'd3
    } state_e;

    // The width counter must be able to hold RESET_CLKS itself, where it saturates.
    function automatic int cnt_width(input int reset_clks);
        return $clog2(reset_clks + 1);
    endfunction

endpackage

// File: rtl/ws2811_sync.sv
// Two-flop synchronizer for the serial line plus rise/fall strobes of the synchronized value.
// Latency: 2 clk to s_o, strobes valid in the cycle s_o changes; no backpressure.
module ws2811_sync (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic data_i,
    output logic s_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= data_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign s_o    = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/ws2811_decoder.sv
// One WS2811 pixel: decodes the first PIXEL_BITS after a latch gap, 4 clk from last falling edge to strobe.
// No backpressure; define WS2811_DECODER_FORWARD_EN to forward later bits on dataOUT (3 clk delay).
module ws2811_decoder
    import ws2811_pkg::*;
#(
    parameter int CLK_HZ         = 50_000_000,
    parameter int THRESHOLD_CLKS = 21,
    parameter int MAX_HIGH_CLKS  = 75,
    parameter int RESET_CLKS     = RESET_CLKS_DEF,
    parameter int PIXEL_BITS     = PIXEL_BITS_DEF
) (
    input  logic                  clkIN,
    input  logic                  nResetIN,
    input  logic                  dataIN,
    output logic [PIXEL_BITS-1:0] pixelOUT,
    output logic                  pixelValidOUT,
    output logic                  frameResetOUT,
    output logic                  bitErrorOUT,
    output logic                  dataOUT
);

    localparam int CW = cnt_width(RESET_CLKS);
    localparam int BW = $clog2(PIXEL_BITS + 1);

    localparam logic [CW-1:0] RESET_C = CW'(RESET_CLKS);
    localparam logic [CW-1:0] MAX_C   = CW'(MAX_HIGH_CLKS);
    localparam logic [CW-1:0] THR_C   = CW'(THRESHOLD_CLKS);
    localparam logic [BW-1:0] LAST_B  = BW'(PIXEL_BITS - 1);

    if (CLK_HZ <= 0 || THRESHOLD_CLKS > MAX_HIGH_CLKS || MAX_HIGH_CLKS >= RESET_CLKS) begin : g_param_check
        $error("ws2811_decoder: inconsistent timing parameters");
    end

    logic s;
    logic rise;
    logic fall;

    ws2811_sync u_sync (
        .clk_i   (clkIN),
        .rst_n_i (nResetIN),
        .data_i  (dataIN),
        .s_o     (s),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         bits_q, bits_d;
    logic [PIXEL_BITS-1:0] shift_q, shift_d;
    logic [PIXEL_BITS-1:0] pixel_q, pixel_d;
    logic                  done_q, done_d;
    logic                  valid_q;
    logic                  frame_q, frame_d;
    logic                  err_q, err_d;

    logic latch_hit;
    logic too_long;
    logic bit_val;

    // cnt_q equals the number of cycles s has held its current level, so on a
    // fall strobe it is exactly the high width just ended.
    always_comb begin
        if (rise || fall) begin
            cnt_d = CW'(1);
        end else if (cnt_q == RESET_C) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign latch_hit = ~s & (cnt_d == RESET_C) & (cnt_q != RESET_C);
    assign too_long  = s & (cnt_d > MAX_C);
    assign bit_val   = (cnt_q >= THR_C);

    always_comb begin
        state_d = state_q;
        bits_d  = bits_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        frame_d = 1'b0;
        err_d   = 1'b0;
        pixel_d = done_q ? shift_q : pixel_q;

        case (state_q)
            ST_SYNC, ST_IDLE, ST_PASS: begin
                if (latch_hit) begin
                    frame_d = 1'b1;
                    bits_d  = '0;
                    shift_d = '0;
                    state_d = ST_IDLE;
                end else if (state_q == ST_IDLE && rise) begin
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (too_long) begin
                    err_d   = 1'b1;
                    bits_d  = '0;
                    shift_d = '0;
                    state_d = ST_SYNC;
                end else if (fall) begin
                    shift_d = {shift_q[PIXEL_BITS-2:0], bit_val};
                    bits_d  = bits_q + BW'(1);
                    if (bits_q == LAST_B) begin
                        done_d  = 1'b1;
                        state_d = ST_PASS;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_SYNC;
        endcase
    end

    always_ff @(posedge clkIN or negedge nResetIN) begin
        if (!nResetIN) begin
            state_q <= ST_SYNC;
            cnt_q   <= '0;
            bits_q  <= '0;
            shift_q <= '0;
            pixel_q <= '0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            frame_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bits_q  <= bits_d;
            shift_q <= shift_d;
            pixel_q <= pixel_d;
            done_q  <= done_d;
            valid_q <= done_q;
            frame_q <= frame_d;
            err_q   <= err_d;
        end
    end

    assign pixelOUT      = pixel_q;
    assign pixelValidOUT = valid_q;
    assign frameResetOUT = frame_q;
    assign bitErrorOUT   = err_q;

`ifdef WS2811_DECODER_FORWARD_EN
    logic fwd_q;

    always_ff @(posedge clkIN or negedge nResetIN) begin
        if (!nResetIN) begin
            fwd_q <= 1'b0;
        end else begin
            fwd_q <= (state_q == ST_PASS) & s;
        end
    end

    assign dataOUT = fwd_q;
`else
    assign dataOUT = 1'b0;
`endif

endmodule

// File: tb/tb_ws2811_decoder.sv
// Directed bench for ws2811_decoder: latch detection, decode, boundaries, errors, reset.
module tb_ws2811_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        din = 1'b0;
    logic [23:0] pix;
    logic        pv;
    logic        fr;
    logic        berr;
    logic        dout;

    int checks = 0;
    int errors = 0;

    int pv_cnt = 0;
    int fr_cnt = 0;
    int err_cnt = 0;
    int fwd_bad = 0;
    int fwd_ones = 0;
    bit fwd_win = 1'b0;
    logic [2:0] hist = 3'b000;

    int pv0, fr0, err0, first;

    ws2811_decoder dut (
        .clkIN         (clk),
        .nResetIN      (rst_n),
        .dataIN        (din),
        .pixelOUT      (pix),
        .pixelValidOUT (pv),
        .frameResetOUT (fr),
        .bitErrorOUT   (berr),
        .dataOUT       (dout)
    );

    always #5 clk = ~clk;

    // Pulse counters and forwarded-line check, sampled 1 time unit after each rising edge.
    always begin
        @(posedge clk);
        hist = {hist[1:0], din};
        #1;
        if (pv === 1'b1) pv_cnt++;
        if (fr === 1'b1) fr_cnt++;
        if (berr === 1'b1) err_cnt++;
`ifdef WS2811_DECODER_FORWARD_EN
        if (fwd_win) begin
            if (dout !== hist[2]) fwd_bad++;
            if (dout === 1'b1) fwd_ones++;
        end
`else
        if (rst_n && dout !== 1'b0) fwd_bad++;
`endif
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input int hi, input int lo);
        din = 1'b1;
        repeat (hi) @(negedge clk);
        din = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic send_bits(input logic [23:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            if (w[i]) pulse(30, 32);
            else      pulse(12, 50);
        end
    endtask

    task automatic gap(input int n);
        din = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        din   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pixel", 32'(pix), 32'h0);
        chk("rst_valid", 32'(pv), 32'h0);
        chk("rst_frame", 32'(fr), 32'h0);
        chk("rst_err", 32'(berr), 32'h0);
        chk("rst_dout", 32'(dout), 32'h0);
        rst_n = 1'b1;

        // 1: latch gap from reset fires exactly once at cycle 2500
        first = 0;
        for (int i = 1; i <= 2600; i++) begin
            @(negedge clk);
            if (fr === 1'b1 && first == 0) first = i;
        end
        chk("t1_latch_cycle", 32'(first), 32'd2500);
        chk("t1_frame_count", 32'(fr_cnt), 32'd1);
        chk("t1_no_valid", 32'(pv_cnt), 32'd0);

        // 2: first word, latency 4 clk after last falling edge
        pv0 = pv_cnt;
        send_bits(24'hA5C3F0 >> 1, 23);
        din = 1'b1;
        repeat (12) @(negedge clk);
        din = 1'b0;
        repeat (3) @(negedge clk);
        chk("t2_valid_at3", 32'(pv), 32'h0);
        @(negedge clk);
        chk("t2_valid_at4", 32'(pv), 32'h1);
        chk("t2_pixel", 32'(pix), 32'hA5C3F0);
        repeat (46) @(negedge clk);
        chk("t2_valid_once", 32'(pv_cnt - pv0), 32'd1);

        // 3: 48 bits, only the first word is taken
        fr0 = fr_cnt;
        gap(2520);
        chk("t3_pre_latch", 32'(fr_cnt - fr0), 32'd1);
        pv0 = pv_cnt;
        send_bits(24'h123456, 24);
        fwd_win = 1'b1;
        send_bits(24'hABCDEF, 24);
        chk("t3_valid_once", 32'(pv_cnt - pv0), 32'd1);
        chk("t3_pixel", 32'(pix), 32'h123456);
        fr0 = fr_cnt;
        gap(2520);
        fwd_win = 1'b0;
        chk("t3_latch", 32'(fr_cnt - fr0), 32'd1);
        chk("t3_forward", 32'(fwd_bad), 32'd0);
`ifdef WS2811_DECODER_FORWARD_EN
        chk("t3_forward_active", 32'(fwd_ones != 0), 32'd1);
`endif

        // 4: threshold boundary 21 -> 1, 20 -> 0, then 76-clk framing error
        pv0 = pv_cnt;
        pulse(21, 50);
        pulse(20, 50);
        send_bits(24'h2AAAAA, 22);
        chk("t4_valid", 32'(pv_cnt - pv0), 32'd1);
        chk("t4_pixel_thresh", 32'(pix), 32'hAAAAAA);
        fr0 = fr_cnt;
        gap(2520);
        chk("t4_latch", 32'(fr_cnt - fr0), 32'd1);
        err0 = err_cnt;
        send_bits(24'h000005, 3);
        pulse(76, 50);
        chk("t4_error", 32'(err_cnt - err0), 32'd1);
        chk("t4_pixel_hold", 32'(pix), 32'hAAAAAA);
        pv0 = pv_cnt;
        send_bits(24'h654321, 24);
        chk("t4_no_decode", 32'(pv_cnt - pv0), 32'd0);
        chk("t4_pixel_hold2", 32'(pix), 32'hAAAAAA);
        fr0 = fr_cnt;
        gap(2520);
        chk("t4_resync", 32'(fr_cnt - fr0), 32'd1);

        // 5: partial word discarded by latch; 75-clk high is still a valid 1
        pv0 = pv_cnt;
        fr0 = fr_cnt;
        send_bits(24'h0003A5, 10);
        gap(2520);
        chk("t5_latch", 32'(fr_cnt - fr0), 32'd1);
        chk("t5_no_valid", 32'(pv_cnt - pv0), 32'd0);
        chk("t5_pixel_hold", 32'(pix), 32'hAAAAAA);
        pv0 = pv_cnt;
        pulse(75, 32);
        send_bits(24'hDA5A5A, 23);
        chk("t5_valid", 32'(pv_cnt - pv0), 32'd1);
        chk("t5_pixel_fresh", 32'(pix), 32'hDA5A5A);

        // 6: reset mid-word, then bits ignored until a latch gap
        fr0 = fr_cnt;
        gap(2520);
        chk("t6_latch", 32'(fr_cnt - fr0), 32'd1);
        send_bits(24'h0000F0, 12);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_rst_pixel", 32'(pix), 32'h0);
        chk("t6_rst_valid", 32'(pv), 32'h0);
        chk("t6_rst_frame", 32'(fr), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_rel_pixel", 32'(pix), 32'h0);
        pv0 = pv_cnt;
        fr0 = fr_cnt;
        send_bits(24'h0F0F0F, 24);
        chk("t6_ignored", 32'(pv_cnt - pv0), 32'd0);
        chk("t6_no_latch", 32'(fr_cnt - fr0), 32'd0);
        chk("t6_pixel_zero", 32'(pix), 32'h0);
        gap(2520);
        chk("t6_resync", 32'(fr_cnt - fr0), 32'd1);
        pv0 = pv_cnt;
        send_bits(24'h0F0F0F, 24);
        chk("t6_valid", 32'(pv_cnt - pv0), 32'd1);
        chk("t6_pixel", 32'(pix), 32'h0F0F0F);

        chk("total_errors", 32'(err_cnt), 32'd1);
        chk("final_forward", 32'(fwd_bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
